// File: rtl/pcs_8b10b_pkg.sv
// Shared 8b/10b code tables and helpers. Sub-block codes are stored in transmission
// order (a/f in the MSB) in their RD- form, with a mask marking which ones invert at RD+.
package pcs_8b10b_pkg;

  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;
  localparam logic       RD_NEG    = 1'b0;
  localparam logic       RD_POS    = 1'b1;

  localparam int NUM_LEGAL_K = 12;
  localparam logic [7:0] LEGAL_K [NUM_LEGAL_K] = '{
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
    8'hF7, 8'hFB, 8'hFD, 8'hFE
  };

  // 5b/6b, abcdei with 'a' in bit 5, RD- column.
  localparam logic [5:0] CODE_6B [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
  };
  // Unbalanced codes plus D.7 (111000/000111) invert when entering at RD+.
  localparam logic [31:0] FLIP_6B     = 32'hE981_8197;
  localparam logic [5:0]  CODE_6B_K28 = 6'b001111;

  // 3b/4b, fghj with 'f' in bit 3, RD- column.
  localparam logic [3:0] CODE_4B_D [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
  };
  localparam logic [7:0] FLIP_4B_D = 8'h99;
  // Control 4b codes all invert with RD, including the otherwise-balanced ones.
  localparam logic [3:0] CODE_4B_K [8] = '{
    4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111
  };
  localparam logic [3:0] CODE_4B_A7 = 4'b0111;

  typedef struct packed {
    logic [9:0] symbol;
    logic       rd;
    logic       k_illegal;
  } enc_result_t;

  function automatic logic is_legal_k(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LEGAL_K; i++) begin
      if (code == LEGAL_K[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/pcs_tx_encoder_8b10b_if.sv
// MAC-side byte bus in, PMA-side symbol bus out of the 8b/10b TX encoder.
interface pcs_tx_encoder_8b10b_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int SYMBOL_WIDTH = 10
);
  logic [DATA_WIDTH-1:0]   Data_in;
  logic                    TxDataK;
  logic                    MAC_Data_En;
  logic [SYMBOL_WIDTH-1:0] Data_out;
  logic                    Data_out_En;
  logic                    RD_out;
  logic                    K_Err;

  modport master (
    output Data_in, TxDataK, MAC_Data_En,
    input  Data_out, Data_out_En, RD_out, K_Err
  );

  modport slave (
    input  Data_in, TxDataK, MAC_Data_En,
    output Data_out, Data_out_En, RD_out, K_Err
  );
endinterface

// File: rtl/enc_8b10b_comb.sv
// Purely combinational 8b/10b encode of one byte at a given entering running disparity.
// Output symbol is packed {j,h,g,f,i,e,d,c,b,a} so bit 0 is serialized first.
module enc_8b10b_comb
  import pcs_8b10b_pkg::*;
(
  input  logic [7:0]  data_in,
  input  logic        k_in,
  input  logic        rd_in,
  output enc_result_t result
);

  logic [4:0] x;
  logic [2:0] y;
  logic       k_bad;
  logic       is_k28;
  logic [5:0] six_neg;
  logic       flip6;
  logic [5:0] six_abcdei;
  logic       rd_mid;
  logic       use_a7;
  logic [3:0] four_neg;
  logic       flip4;
  logic [3:0] four_fghj;
  logic       rd_end;
  logic [5:0] six_out;
  logic [3:0] four_out;

  assign x = data_in[4:0];
  assign y = data_in[7:5];

  always_comb begin
    k_bad      = k_in && !is_legal_k(data_in);
    is_k28     = k_in && (x == 5'd28);
    six_neg    = is_k28 ? CODE_6B_K28 : CODE_6B[x];
    flip6      = is_k28 || FLIP_6B[x];
    six_abcdei = (rd_in && flip6) ? ~six_neg : six_neg;

    if ($countones(six_abcdei) > 3)      rd_mid = RD_POS;
    else if ($countones(six_abcdei) < 3) rd_mid = RD_NEG;
    else                                 rd_mid = rd_in;

    // A7 avoids a run of five across the 6b/4b boundary for these x values.
    use_a7 = (y == 3'd7) &&
             (k_in ||
              ((rd_mid == RD_NEG) && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
              ((rd_mid == RD_POS) && (x == 5'd11 || x == 5'd13 || x == 5'd14)));

    four_neg  = use_a7 ? CODE_4B_A7 : (k_in ? CODE_4B_K[y] : CODE_4B_D[y]);
    flip4     = use_a7 || k_in || FLIP_4B_D[y];
    four_fghj = (rd_mid && flip4) ? ~four_neg : four_neg;

    if ($countones(four_fghj) > 2)      rd_end = RD_POS;
    else if ($countones(four_fghj) < 2) rd_end = RD_NEG;
    else                                rd_end = rd_mid;
  end

  // Tables hold transmission order MSB-first; the output wants 'a' in bit 0.
  for (genvar gi = 0; gi < 6; gi++) begin : g_rev6
    assign six_out[gi] = six_abcdei[5-gi];
  end
  for (genvar gi = 0; gi < 4; gi++) begin : g_rev4
    assign four_out[gi] = four_fghj[3-gi];
  end

  always_comb begin
    result.k_illegal = k_bad;
    if (k_bad) begin
      // Substitute K28.5; its symbol is unbalanced so RD always flips.
      result.symbol = (rd_in == RD_POS) ? K28_5_RDP : K28_5_RDN;
      result.rd     = ~rd_in;
    end else begin
      result.symbol = {four_out, six_out};
      result.rd     = rd_end;
    end
  end

endmodule

// File: rtl/pcs_tx_encoder_8b10b.sv
// TX PCS 8b/10b encoder: qualifies MAC bytes, encodes them and registers the symbol
// and running disparity toward PMA_TX with one cycle of latency.
module pcs_tx_encoder_8b10b
  import pcs_8b10b_pkg::*;
#(
  parameter int   DATA_WIDTH   = 8,
  parameter int   SYMBOL_WIDTH = 10,
  parameter logic RD_INIT      = RD_NEG
) (
  input  logic                 Bit_Rate_Clk_10,
  input  logic                 Rst_n,
  pcs_tx_encoder_8b10b_if.slave bus
);

  logic [DATA_WIDTH-1:0]   byte_in;
  enc_result_t             enc;
  logic [SYMBOL_WIDTH-1:0] data_out_reg;
  logic                    data_out_en_reg;
  logic                    rd_reg;
  logic                    k_err_reg;

  assign byte_in = bus.Data_in;

  enc_8b10b_comb u_enc (
    .data_in (byte_in),
    .k_in    (bus.TxDataK),
    .rd_in   (rd_reg),
    .result  (enc)
  );

  // Idle cycles keep the last symbol and RD; only the strobes drop.
  always_ff @(posedge Bit_Rate_Clk_10) begin
    if (!Rst_n) begin
      data_out_reg    <= '0;
      data_out_en_reg <= 1'b0;
      rd_reg          <= RD_INIT;
      k_err_reg       <= 1'b0;
    end else if (bus.MAC_Data_En) begin
      data_out_reg    <= enc.symbol;
      data_out_en_reg <= 1'b1;
      rd_reg          <= enc.rd;
      k_err_reg       <= enc.k_illegal;
    end else begin
      data_out_en_reg <= 1'b0;
      k_err_reg       <= 1'b0;
    end
  end

  assign bus.Data_out    = data_out_reg;
  assign bus.Data_out_En = data_out_en_reg;
  assign bus.RD_out      = rd_reg;
  assign bus.K_Err       = k_err_reg;

endmodule
